// File: rtl/uart_hamming_transmitter_pkg.sv
// Shared definitions for the Hamming(7,4) UART link: frame state encoding,
// codeword width and default oversampling ratio.
package uart_hamming_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int HAMMING_BITS       = 7;
    localparam int DEFAULT_OVERSAMPLE = 8;

endpackage

// File: rtl/uart_hamming_transmitter_encoder.sv
// Combinational Hamming(7,4) encoder: {d4,d3,d2,d1} -> {d4,d3,d2,p3,d1,p2,p1}.
module uart_hamming_transmitter_encoder
    import uart_hamming_transmitter_pkg::*;
(
    input  logic [3:0]              i_data,
    output logic [HAMMING_BITS-1:0] o_codeword
);

    logic w_d1, w_d2, w_d3, w_d4;
    logic w_p1, w_p2, w_p3;

    assign w_d1 = i_data[0];
    assign w_d2 = i_data[1];
    assign w_d3 = i_data[2];
    assign w_d4 = i_data[3];

    assign w_p1 = w_d1 ^ w_d2 ^ w_d4;
    assign w_p2 = w_d1 ^ w_d3 ^ w_d4;
    assign w_p3 = w_d2 ^ w_d3 ^ w_d4;

    assign o_codeword = {w_d4, w_d3, w_d2, w_p3, w_d1, w_p2, w_p1};

endmodule

// File: rtl/uart_hamming_transmitter.sv
// Hamming(7,4) UART transmitter: accepts a nibble, sends start, 7 codeword
// bits LSB first and stop, each bit held for OVERSAMPLE ena ticks.
module uart_hamming_transmitter
    import uart_hamming_transmitter_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [2:0] state_out
);

    localparam int            TW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(HAMMING_BITS - 1);

    tx_state_t               r_state, w_state_nxt;
    logic [TW-1:0]           r_tick, w_tick_nxt;
    logic [2:0]              r_bit, w_bit_nxt;
    logic [HAMMING_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [HAMMING_BITS-1:0] w_codeword;
    logic                    r_tx, w_tx_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_bit_end;

    uart_hamming_transmitter_encoder u_encoder (
        .i_data     (data_in),
        .o_codeword (w_codeword)
    );

    assign w_bit_end = ena && (r_tick == TICK_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;

        // The tick counter only runs inside a frame; acceptance itself is not a tick.
        if ((r_state != ST_IDLE) && ena) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick + TW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (data_valid) begin
                    w_shreg_nxt = w_codeword;
                    w_state_nxt = ST_START;
                    w_tick_nxt  = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shreg[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // tx takes the bit that becomes shreg[0] after this shift.
                        w_shreg_nxt = r_shreg >> 1;
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shreg[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign data_ready = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign tx         = r_tx;
    assign tx_done    = r_done;
    assign state_out  = {1'b0, r_state};

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Bench for uart_hamming_transmitter: random nibbles and ena patterns checked
// clock by clock against a frame-level model of the serial line.
module tb_uart_hamming_transmitter;

    localparam int OS    = 8;
    localparam int FRAME = 9 * OS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       data_valid = 1'b0;
    logic       data_ready, tx, busy, tx_done;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_hamming_transmitter #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .state_out  (state_out)
    );

    // Hamming positions 1..7: data at non-powers of two, parity at 1,2,4
    // covering every position whose index has that bit set.
    function automatic logic [6:0] ref_codeword(input logic [3:0] nib);
        logic [7:1] w;
        int di;
        logic p;
        w  = '0;
        di = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = nib[di];
                di++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if ((((pos >> j) & 1) == 1) && (pos != (1 << j))) p = p ^ w[pos];
            end
            w[1 << j] = p;
        end
        return w;
    endfunction

    // One frame: waits for ready, accepts nib, then follows the line every clk.
    task automatic run_frame(input logic [3:0] nib, input int period, input bit keep_valid,
                             input logic [3:0] next_nib, output int wait_cycles, output int done_cyc);
        logic [8:0] fr, rx;
        logic [2:0] exp_state;
        logic       exp_tx, exp_done, exp_busy;
        int         n, cyc;
        bit         e;
        fr = {1'b1, ref_codeword(nib), 1'b0};
        rx = '0;
        wait_cycles = 0;
        done_cyc = -1;
        while (data_ready !== 1'b1 && wait_cycles < 200) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        checks++;
        if (data_ready !== 1'b1 || tx !== 1'b1)
            begin errors++; $display("FAIL idle_before_accept ready=%b tx=%b required 1 1", data_ready, tx); end
        data_in    = nib;
        data_valid = 1'b1;
        ena        = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0 || data_ready !== 1'b0 || state_out !== 3'd1 || tx_done !== 1'b0)
            begin errors++; $display("FAIL accept busy=%b tx=%b ready=%b state=%0d done=%b required 1 0 0 1 0",
                                     busy, tx, data_ready, state_out, tx_done); end
        data_valid = keep_valid;
        data_in    = keep_valid ? next_nib : 4'($urandom);
        n   = 0;
        cyc = 0;
        while (n < FRAME && cyc < FRAME * period + 20) begin
            e   = ((cyc % period) == 0);
            ena = e;
            if (!keep_valid) begin
                data_in    = 4'($urandom);
                data_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
            if (e) n++;
            if (n < FRAME && (n % OS) == OS / 2) rx[n / OS] = tx;
            exp_tx    = (n >= FRAME) ? 1'b1 : fr[n / OS];
            exp_done  = e && (n == FRAME);
            exp_busy  = (n < FRAME);
            exp_state = (n >= FRAME) ? 3'd0 : (n < OS) ? 3'd1 : (n < 8 * OS) ? 3'd2 : 3'd3;
            if (exp_done) done_cyc = cyc;
            checks++;
            if (tx !== exp_tx || tx_done !== exp_done || busy !== exp_busy ||
                data_ready !== !exp_busy || state_out !== exp_state)
                begin errors++; $display("FAIL line nib=%h clk=%0d tick=%0d tx=%b done=%b busy=%b ready=%b state=%0d required %b %b %b %b %0d",
                                         nib, cyc, n, tx, tx_done, busy, data_ready, state_out,
                                         exp_tx, exp_done, exp_busy, !exp_busy, exp_state); end
        end
        if (!keep_valid) data_valid = 1'b0;
        checks++;
        if (n != FRAME)
            begin errors++; $display("FAIL frame_timeout ticks=%0d required %0d", n, FRAME); end
        checks++;
        if (rx !== fr)
            begin errors++; $display("FAIL loopback nib=%h received=%h required %h", nib, rx, fr); end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        data_valid = 1'b1;
        data_in    = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            ena = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        checks++;
        if (tx !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0 || state_out !== 3'd0 || tx_done !== 1'b0)
            begin errors++; $display("FAIL reset tx=%b ready=%b busy=%b state=%0d done=%b required 1 1 0 0 0",
                                     tx, data_ready, busy, state_out, tx_done); end
        data_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || state_out !== 3'd0)
            begin errors++; $display("FAIL post_reset_idle tx=%b busy=%b state=%0d required 1 0 0", tx, busy, state_out); end
    endtask

    task automatic test_encode();
        int w, d;
        run_frame(4'b1011, 1, 1'b0, 4'd0, w, d);
        checks++;
        if (ref_codeword(4'b1011) !== 7'h55)
            begin errors++; $display("FAIL ref_codeword got=%h required 55", ref_codeword(4'b1011)); end
        checks++;
        if (d != 72)
            begin errors++; $display("FAIL tx_done_clk got=%0d required 72", d); end
    endtask

    task automatic test_ena_gating();
        int w, d;
        run_frame(4'($urandom), 4, 1'b0, 4'd0, w, d);
        checks++;
        if (d != FRAME * 4 - 3)
            begin errors++; $display("FAIL gated_done_clk got=%0d required %0d", d, FRAME * 4 - 3); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        int w, d;
        a = 4'($urandom);
        b = ~a;
        run_frame(a, 1, 1'b1, b, w, d);
        run_frame(b, 1, 1'b0, 4'd0, w, d);
        checks++;
        if (w != 0)
            begin errors++; $display("FAIL back_to_back_gap waited=%0d required 0", w); end
    endtask

    task automatic test_loopback();
        int w, d;
        for (int i = 0; i < 16; i++) run_frame(4'(i), $urandom_range(1, 3), 1'b0, 4'd0, w, d);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] nib;
        logic [6:0] cw;
        int w, d;
        nib = 4'($urandom);
        cw  = ref_codeword(nib);
        data_in    = nib;
        data_valid = 1'b1;
        ena        = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < OS + 3 * OS + 3; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tx !== cw[3] || state_out !== 3'd2)
            begin errors++; $display("FAIL mid_data tx=%b state=%0d required %b 2", tx, state_out, cw[3]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || state_out !== 3'd0 || busy !== 1'b0 || data_ready !== 1'b1)
            begin errors++; $display("FAIL async_reset tx=%b state=%0d busy=%b ready=%b required 1 0 0 1",
                                     tx, state_out, busy, data_ready); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL no_resume tx=%b busy=%b required 1 0", tx, busy); end
        run_frame(4'($urandom), 1, 1'b0, 4'd0, w, d);
        run_frame(4'($urandom), 2, 1'b0, 4'd0, w, d);
    endtask

    initial begin
        test_reset();
        test_encode();
        test_ena_gating();
        test_back_to_back();
        test_loopback();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
